// File: rtl/timer_ctrl_if.sv
// Control/status bundle between a timer user and timer_ctrl.
// Latency: none, wires only.
// Backpressure: none; start/stop are level requests sampled by the timer FSM.
interface timer_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         stop;
    logic         oneshot;
    logic [N-1:0] period;
    logic         busy;
    logic         tick;
    logic         done;
    logic         err;
    logic [N-1:0] cnt;

    // User side: issues requests, observes status.
    modport master (
        output start, stop, oneshot, period,
        input  busy, tick, done, err, cnt
    );

    // Timer side: samples requests, drives status.
    modport slave (
        input  start, stop, oneshot, period,
        output busy, tick, done, err, cnt
    );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable one-shot/periodic timer: IDLE -> RUN -> FINISH; optional prescaler via TIMER_CTRL_PRESCALE_EN.
// Latency: RUN one cycle after accepted start; tick in RUN cycle `period` (period*P with prescaler).
// Backpressure: none; start only honoured in IDLE, stop only in RUN, stop beats terminal count.
module timer_ctrl #(
    parameter int N = 8,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  tmr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // The prescaler wraps at P-1, so fewer than two phases is meaningless.
    if (P < 2) begin : g_p_check
        $error("timer_ctrl: P must be >= 2");
    end

    state_t       state;
    logic [N-1:0] cnt_q;
    logic [N-1:0] limit;
    logic         mode_oneshot;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
    logic         adv;
    logic         tick_c;

`ifdef TIMER_CTRL_PRESCALE_EN
    localparam int PW = $clog2(P);
    localparam logic [PW-1:0] PRESC_LAST = PW'(P - 1);

    logic [PW-1:0] presc;

    assign adv = (presc == PRESC_LAST);

    // Prescaler runs only in RUN; it sits at 0 elsewhere, so every accepted start begins a fresh phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (state != RUN) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end
`else
    assign adv = 1'b1;
`endif

    // Terminal count; a same-cycle stop suppresses it.
    assign tick_c = (state == RUN) && (cnt_q == limit) && adv && !tmr.stop;

    // Main FSM with registered busy/done/err and the count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt_q        <= '0;
            limit        <= '0;
            mode_oneshot <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (tmr.start) begin
                        if (tmr.period != '0) begin
                            // Storing period-1 keeps period = 2^N-1 within N bits.
                            limit        <= tmr.period - 1'b1;
                            mode_oneshot <= tmr.oneshot;
                            state        <= RUN;
                            busy_q       <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (tmr.stop || (tick_c && mode_oneshot)) begin
                        state  <= FINISH;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                    end else if (tick_c) begin
                        cnt_q <= '0;
                    end else if (adv) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    cnt_q <= '0;
                end
                default: begin
                    state  <= IDLE;
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign tmr.busy = busy_q;
    assign tmr.done = done_q;
    assign tmr.err  = err_q;
    assign tmr.tick = tick_c;
    assign tmr.cnt  = cnt_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomised and directed bench for timer_ctrl with a cycle-level scoreboard.
// Latency: expected outputs are queued per cycle and checked by an independent monitor.
// Backpressure: none; the monitor drains one entry per cycle.
module tb_timer_ctrl;

    localparam int N    = 8;
`ifdef TIMER_CTRL_PRESCALE_EN
    localparam int P_TB = 4;
`else
    localparam int P_TB = 1;
`endif

    logic clk;
    logic rst;

    timer_ctrl_if #(.N(N)) tif ();

`ifdef TIMER_CTRL_PRESCALE_EN
    timer_ctrl #(.N(N), .P(P_TB)) dut (.clk(clk), .reset(rst), .tmr(tif.slave));
`else
    timer_ctrl #(.N(N)) dut (.clk(clk), .reset(rst), .tmr(tif.slave));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic         busy;
        logic         tick;
        logic         done;
        logic         err;
        logic [N-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_no = 0;

    // Reference model: phase 0 idle, 1 running, 2 finishing; m_e counts cycles spent running.
    int   m_ph  = 0;
    int   m_e   = 0;
    int   m_per = 1;
    logic m_os  = 1'b0;
    logic m_err = 1'b0;

    function automatic logic period_end(input int e, input int per);
        return ((e % P_TB) == P_TB - 1) && (((e / P_TB) % per) == per - 1);
    endfunction

    task automatic chk(input string name, input int cyc, input logic [N-1:0] got, input logic [N-1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
    endtask

    // One clock cycle: drive inputs, queue the model's expectation, then advance the model at the edge.
    task automatic cyc(input logic r, input logic s, input logic sp, input logic os, input logic [N-1:0] p);
        exp_t x;
        logic tk;
        @(negedge clk);
        rst         = r;
        tif.start   = s;
        tif.stop    = sp;
        tif.oneshot = os;
        tif.period  = p;
        cyc_no++;
        x.cyc  = cyc_no;
        x.busy = (m_ph == 1);
        x.done = (m_ph == 2);
        x.err  = m_err;
        tk     = (m_ph == 1) && !sp && period_end(m_e, m_per);
        x.tick = tk;
        x.cnt  = (m_ph == 1) ? N'((m_e / P_TB) % m_per) : '0;
        exp_q.push_back(x);
        @(posedge clk);
        if (r) begin
            m_ph  = 0;
            m_err = 1'b0;
        end else begin
            m_err = (m_ph == 0) && s && (p == 0);
            case (m_ph)
                0: if (s && p != 0) begin
                    m_ph  = 1;
                    m_e   = 0;
                    m_per = int'(p);
                    m_os  = os;
                end
                1: begin
                    if (sp || (tk && m_os)) m_ph = 2;
                    else m_e++;
                end
                default: m_ph = 0;
            endcase
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, $urandom_range(0, 1), N'($urandom));
    endtask

    // Monitor: compares every presented output set against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                exp_t x;
                x = exp_q.pop_front();
                chk("busy", x.cyc, N'(tif.busy), N'(x.busy));
                chk("tick", x.cyc, N'(tif.tick), N'(x.tick));
                chk("done", x.cyc, N'(tif.done), N'(x.done));
                chk("err",  x.cyc, N'(tif.err),  N'(x.err));
                chk("cnt",  x.cyc, tif.cnt, x.cnt);
            end
        end
    end

    int tick_seen;

    initial begin
        rst         = 1'b1;
        tif.start   = 1'b0;
        tif.stop    = 1'b0;
        tif.oneshot = 1'b0;
        tif.period  = '0;
        @(posedge clk);
        m_ph  = 0;
        m_err = 1'b0;

        // Reset state, with junk on the request lines.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        idle_n(2);

        // Periodic, period 5: three ticks, then stop.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        for (int i = 0; i < 16 * P_TB; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        idle_n(3);

        // One-shot, period 3, with period/mode changing mid-run.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
        for (int i = 0; i < 5 * P_TB; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd7);
        idle_n(2);

        // Stop exactly at terminal count, period 4.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        for (int i = 0; i < 4 * P_TB - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        idle_n(3);

        // Rejected start, then period 1 periodic.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        idle_n(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 0; i < 6 * P_TB; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle_n(2);

        // Reset mid-run (period 8), then a fresh one-shot start.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd8);
        idle_n(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
        for (int i = 0; i < 4 * P_TB; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Maximum period one-shot: wraps nothing, ticks at 255.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
        tick_seen = 0;
        for (int i = 0; i < 257 * P_TB; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            if (tif.tick === 1'b1) tick_seen++;
        end
        idle_n(2);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [N-1:0] p;
            if ($urandom_range(0, 19) == 0) p = 8'hFF;
            else p = N'($urandom_range(0, 6));
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 5,
                $urandom_range(0, 1),
                p);
        end
        idle_n(2);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #5;
        chk("drain", cyc_no, N'(exp_q.size()), N'(0));
        chk("maxper_ticks", cyc_no, N'(tick_seen), N'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
